// File: rtl/bru_pkg.sv
// Shared defaults and entry type for the branch resolve unit.
// Optional statistics counters are enabled with the BRU_STATS_EN macro (see branch_resolve_unit).
package bru_pkg;

   localparam int BRU_DEPTH = 4;
   localparam int BRU_PC_W  = 32;

   typedef struct packed {
      logic                pred;
      logic [BRU_PC_W-1:0] target;
      logic [BRU_PC_W-1:0] fallthru;
   } br_entry_t;

endpackage

// File: rtl/br_pred_fifo.sv
// In-flight branch queue: DEPTH register entries with push/pop/clear and head read-out.
// Pointers carry one extra wrap bit so full and empty are distinguished without a counter.
module br_pred_fifo
   import bru_pkg::*;
#(
   parameter int  DEPTH = BRU_DEPTH,
   parameter type T     = br_entry_t
) (
   input  logic clk,
   input  logic rst,
   input  logic i_push,
   input  logic i_pop,
   input  logic i_clear,
   input  T     i_push_data,
   output T     o_head,
   output logic o_full,
   output logic o_empty
);

   localparam int PTR_W = $clog2(DEPTH) + 1;

   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   T                 r_mem [DEPTH];

   logic [PTR_W-2:0] w_head_idx;
   logic [PTR_W-2:0] w_tail_idx;

   assign w_head_idx = r_head[PTR_W-2:0];
   assign w_tail_idx = r_tail[PTR_W-2:0];

   assign o_empty = (r_head == r_tail);
   assign o_full  = (r_head[PTR_W-1] != r_tail[PTR_W-1]) && (w_head_idx == w_tail_idx);
   assign o_head  = r_mem[w_head_idx];

   // Clear drops every in-flight entry by snapping head onto tail.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head <= '0;
         r_tail <= '0;
      end else if (i_clear) begin
         r_head <= r_tail;
      end else begin
         if (i_push) r_tail <= r_tail + PTR_W'(1);
         if (i_pop)  r_head <= r_head + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (i_push && !i_clear) r_mem[w_tail_idx] <= i_push_data;
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves in-flight predicted branches against EX outcomes; drives B/PreWrong and a flush/redirect.
// Define BRU_STATS_EN to add stat_br_cnt / stat_miss_cnt event counters.
module branch_resolve_unit
   import bru_pkg::*;
#(
   parameter int DEPTH = BRU_DEPTH,
   parameter int PC_W  = BRU_PC_W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            if_br_valid,
   input  logic            if_br_pred,
   input  logic [PC_W-1:0] if_pc_target,
   input  logic [PC_W-1:0] if_pc_fallthru,
   input  logic            ex_br_valid,
   input  logic            ex_br_taken,
   output logic            B,
   output logic            PreWrong,
   output logic            flush,
   output logic [PC_W-1:0] redirect_pc,
   output logic            q_full,
   output logic            q_empty,
   output logic            err_underflow
`ifdef BRU_STATS_EN
   ,
   output logic [31:0]     stat_br_cnt,
   output logic [31:0]     stat_miss_cnt
`endif
);

   typedef struct packed {
      logic            pred;
      logic [PC_W-1:0] target;
      logic [PC_W-1:0] fallthru;
   } entry_t;

   entry_t          w_push_entry;
   entry_t          w_head;
   logic            w_full;
   logic            w_empty;
   logic            w_push;
   logic            w_pop;
   logic            w_miss;

   logic            r_flush;
   logic [PC_W-1:0] r_redirect_pc;
   logic            r_err_underflow;

   assign w_push_entry = '{pred: if_br_pred, target: if_pc_target, fallthru: if_pc_fallthru};

   assign w_pop  = ex_br_valid && !stall && !w_empty;
   assign w_miss = w_pop && (w_head.pred != ex_br_taken);
   // A fetch push in the miss cycle is wrong-path work and is dropped with the rest.
   assign w_push = if_br_valid && !stall && (!w_full || w_pop) && !w_miss;

   br_pred_fifo #(
      .DEPTH (DEPTH),
      .T     (entry_t)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push),
      .i_pop       (w_pop),
      .i_clear     (w_miss),
      .i_push_data (w_push_entry),
      .o_head      (w_head),
      .o_full      (w_full),
      .o_empty     (w_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_flush         <= 1'b0;
         r_redirect_pc   <= '0;
         r_err_underflow <= 1'b0;
      end else begin
         r_flush <= w_miss;
         if (w_miss) r_redirect_pc <= ex_br_taken ? w_head.target : w_head.fallthru;
         if (ex_br_valid && w_empty && !stall) r_err_underflow <= 1'b1;
      end
   end

`ifdef BRU_STATS_EN
   logic [31:0] r_stat_br_cnt;
   logic [31:0] r_stat_miss_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stat_br_cnt   <= '0;
         r_stat_miss_cnt <= '0;
      end else begin
         if (w_pop)  r_stat_br_cnt   <= r_stat_br_cnt + 32'd1;
         if (w_miss) r_stat_miss_cnt <= r_stat_miss_cnt + 32'd1;
      end
   end

   assign stat_br_cnt   = r_stat_br_cnt;
   assign stat_miss_cnt = r_stat_miss_cnt;
`endif

   assign B             = w_pop;
   assign PreWrong      = w_miss;
   assign flush         = r_flush;
   assign redirect_pc   = r_redirect_pc;
   assign q_full        = w_full;
   assign q_empty       = w_empty;
   assign err_underflow = r_err_underflow;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a reference queue of predictions predicts B/PreWrong,
// flush/redirect, full/empty and the underflow flag.
module tb_branch_resolve_unit;

   localparam int DEPTH = 4;
   localparam int PC_W  = 32;

   typedef struct {
      logic        pred;
      logic [31:0] target;
      logic [31:0] fallthru;
   } sb_entry_t;

   logic            clk = 1'b0;
   logic            rst, stall, if_br_valid, if_br_pred, ex_br_valid, ex_br_taken;
   logic [PC_W-1:0] if_pc_target, if_pc_fallthru;
   logic            B, PreWrong, flush, q_full, q_empty, err_underflow;
   logic [PC_W-1:0] redirect_pc;
`ifdef BRU_STATS_EN
   logic [31:0]     stat_br_cnt, stat_miss_cnt;
`endif

   branch_resolve_unit #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .if_br_valid    (if_br_valid),
      .if_br_pred     (if_br_pred),
      .if_pc_target   (if_pc_target),
      .if_pc_fallthru (if_pc_fallthru),
      .ex_br_valid    (ex_br_valid),
      .ex_br_taken    (ex_br_taken),
      .B              (B),
      .PreWrong       (PreWrong),
      .flush          (flush),
      .redirect_pc    (redirect_pc),
      .q_full         (q_full),
      .q_empty        (q_empty),
      .err_underflow  (err_underflow)
`ifdef BRU_STATS_EN
      ,
      .stat_br_cnt    (stat_br_cnt),
      .stat_miss_cnt  (stat_miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   sb_entry_t   sb_q[$];
   logic        e_B, e_pw, e_flush, e_err;
   logic [31:0] e_redirect;
   logic [31:0] e_br_cnt, e_miss_cnt;

   // Apply one cycle of inputs and derive the expected combinational response from the scoreboard.
   task automatic drive(input logic r, input logic v, input logic p, input logic [31:0] t,
                        input logic [31:0] f, input logic ev, input logic et, input logic st);
      rst = r; if_br_valid = v; if_br_pred = p; if_pc_target = t; if_pc_fallthru = f;
      ex_br_valid = ev; ex_br_taken = et; stall = st;
      e_B  = ev && !st && (sb_q.size() > 0);
      e_pw = e_B && (sb_q[0].pred != et);
      #2;
   endtask

   // Clock edge: retire the expected results into the scoreboard state.
   task automatic tick();
      logic push;
      sb_entry_t ent;
      push = if_br_valid && !stall && ((sb_q.size() < DEPTH) || e_B) && !e_pw;
      ent.pred = if_br_pred; ent.target = if_pc_target; ent.fallthru = if_pc_fallthru;
      if (rst) begin
         sb_q.delete(); e_flush = 0; e_redirect = 0; e_err = 0; e_br_cnt = 0; e_miss_cnt = 0;
      end else begin
         if (ex_br_valid && !stall && sb_q.size() == 0) e_err = 1;
         if (e_B) e_br_cnt++;
         if (e_pw) e_miss_cnt++;
         e_flush = e_pw;
         if (e_pw) begin
            e_redirect = ex_br_taken ? sb_q[0].target : sb_q[0].fallthru;
            sb_q.delete();
         end else begin
            if (e_B) void'(sb_q.pop_front());
            if (push) sb_q.push_back(ent);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_reset();
      drive(1, 0, 0, 0, 0, 0, 0, 0); tick(); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", flush); end
      checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect got %h exp 0", redirect_pc); end
      checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_underflow); end
      checks++; if (q_empty !== 1'b1 || q_full !== 1'b0) begin errors++; $display("FAIL reset_flags empty=%b full=%b exp 1/0", q_empty, q_full); end
   endtask

   task automatic test_correct_pred();
      drive(0, 1, 1, 32'h100, 32'h44, 0, 0, 0); tick();
      drive(0, 0, 0, 0, 0, 1, 1, 0);
      checks++; if (B !== 1'b1 || B !== e_B) begin errors++; $display("FAIL correct_B got %b exp %b", B, e_B); end
      checks++; if (PreWrong !== 1'b0) begin errors++; $display("FAIL correct_prewrong got %b exp 0", PreWrong); end
      tick();
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL correct_flush got %b exp 0", flush); end
      checks++; if (q_empty !== 1'b1) begin errors++; $display("FAIL correct_empty got %b exp 1", q_empty); end
   endtask

   task automatic test_mispredict();
      drive(0, 1, 0, 32'h200, 32'h48, 0, 0, 0); tick();
      drive(0, 0, 0, 0, 0, 1, 1, 0);
      checks++; if (PreWrong !== 1'b1 || PreWrong !== e_pw) begin errors++; $display("FAIL miss_prewrong got %b exp %b", PreWrong, e_pw); end
      tick();
      checks++; if (flush !== 1'b1) begin errors++; $display("FAIL miss_flush got %b exp 1", flush); end
      checks++; if (redirect_pc !== 32'h200) begin errors++; $display("FAIL miss_redirect got %h exp 00000200", redirect_pc); end
      // Predicted taken, actually not taken: redirect goes to the fall-through PC; stall right after.
      drive(0, 1, 1, 32'h300, 32'h4c, 0, 0, 0); tick();
      drive(0, 0, 0, 0, 0, 1, 0, 0); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      checks++; if (flush !== e_flush || redirect_pc !== e_redirect) begin errors++; $display("FAIL miss_ft flush=%b pc=%h exp %b/%h", flush, redirect_pc, e_flush, e_redirect); end
      tick();
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL flush_pulse got %b exp 0", flush); end
      checks++; if (redirect_pc !== 32'h4c) begin errors++; $display("FAIL redirect_hold got %h exp 0000004c", redirect_pc); end
   endtask

   task automatic test_miss_discard();
      drive(0, 1, 0, 32'h400, 32'h50, 0, 0, 0); tick();
      drive(0, 1, 1, 32'h500, 32'h54, 0, 0, 0); tick();
      drive(0, 1, 1, 32'h600, 32'h58, 0, 0, 0); tick();
      drive(0, 1, 1, 32'h700, 32'h5c, 1, 1, 0);
      checks++; if (PreWrong !== e_pw || B !== e_B) begin errors++; $display("FAIL discard_resolve B=%b pw=%b exp %b/%b", B, PreWrong, e_B, e_pw); end
      tick();
      checks++; if (q_empty !== 1'b1 || sb_q.size() != 0) begin errors++; $display("FAIL discard_empty got %b exp 1", q_empty); end
      checks++; if (redirect_pc !== 32'h400 || flush !== 1'b1) begin errors++; $display("FAIL discard_redirect pc=%h flush=%b exp 00000400/1", redirect_pc, flush); end
      idle();
   endtask

   task automatic test_full();
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, ~i[0], 32'h1000 + 32'(i * 16), 32'h2000 + 32'(i * 4), 0, 0, 0); tick();
         drive(0, 0, 0, 0, 0, 0, 0, 0);
         checks++; if (q_full !== (sb_q.size() == DEPTH)) begin errors++; $display("FAIL full_fill[%0d] got %b exp %b", i, q_full, sb_q.size() == DEPTH); end
      end
      drive(0, 1, 0, 32'h3000, 32'h3004, 1, sb_q[0].pred, 0);
      checks++; if (B !== 1'b1 || PreWrong !== 1'b0) begin errors++; $display("FAIL full_pushpop B=%b pw=%b exp 1/0", B, PreWrong); end
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (q_full !== 1'b1) begin errors++; $display("FAIL full_stays got %b exp 1", q_full); end
      // Resolve in order with the outcome the scoreboard head predicts; any reordering shows as PreWrong.
      for (int i = 0; i < DEPTH; i++) begin
         drive(0, 0, 0, 0, 0, 1, sb_q[0].pred, 0);
         checks++; if (B !== 1'b1 || PreWrong !== 1'b0) begin errors++; $display("FAIL full_drain[%0d] B=%b pw=%b exp 1/0", i, B, PreWrong); end
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (q_empty !== 1'b1) begin errors++; $display("FAIL full_drained got %b exp 1", q_empty); end
   endtask

   task automatic test_stall();
      drive(0, 1, 1, 32'h800, 32'h60, 0, 0, 0); tick();
      drive(0, 1, 0, 32'h900, 32'h64, 1, 0, 1);
      checks++; if (B !== 1'b0 || PreWrong !== 1'b0) begin errors++; $display("FAIL stall_outputs B=%b pw=%b exp 0/0", B, PreWrong); end
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (q_empty !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL stall_hold empty=%b flush=%b exp 0/0", q_empty, flush); end
      drive(0, 0, 0, 0, 0, 1, 1, 0);
      checks++; if (B !== 1'b1 || PreWrong !== 1'b0) begin errors++; $display("FAIL stall_release B=%b pw=%b exp 1/0", B, PreWrong); end
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (q_empty !== 1'b1 || err_underflow !== 1'b0) begin errors++; $display("FAIL stall_drop empty=%b err=%b exp 1/0", q_empty, err_underflow); end
   endtask

   task automatic test_underflow_and_reset();
      drive(0, 0, 0, 0, 0, 1, 1, 0);
      checks++; if (B !== 1'b0) begin errors++; $display("FAIL uflow_B got %b exp 0", B); end
      tick(); idle(); idle();
      checks++; if (err_underflow !== 1'b1 || err_underflow !== e_err) begin errors++; $display("FAIL uflow_sticky got %b exp 1", err_underflow); end
      drive(0, 1, 0, 32'ha00, 32'h68, 1, 1, 0);
      checks++; if (B !== 1'b0) begin errors++; $display("FAIL pushpop_empty_B got %b exp 0", B); end
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (q_empty !== 1'b0) begin errors++; $display("FAIL pushpop_empty_push got %b exp 0", q_empty); end
`ifdef BRU_STATS_EN
      checks++; if (stat_br_cnt !== e_br_cnt || stat_miss_cnt !== e_miss_cnt) begin errors++; $display("FAIL stats br=%0d miss=%0d exp %0d/%0d", stat_br_cnt, stat_miss_cnt, e_br_cnt, e_miss_cnt); end
`endif
      // Reset lands together with a mispredict: the reset wins and no flush follows.
      drive(1, 1, 1, 32'hb00, 32'h6c, 1, 1, 0); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (flush !== 1'b0 || redirect_pc !== 32'h0) begin errors++; $display("FAIL rst_mid flush=%b pc=%h exp 0/0", flush, redirect_pc); end
      checks++; if (err_underflow !== 1'b0 || q_empty !== 1'b1 || q_full !== 1'b0) begin errors++; $display("FAIL rst_mid_flags err=%b empty=%b full=%b exp 0/1/0", err_underflow, q_empty, q_full); end
`ifdef BRU_STATS_EN
      checks++; if (stat_br_cnt !== 32'd0 || stat_miss_cnt !== 32'd0) begin errors++; $display("FAIL stats_rst br=%0d miss=%0d exp 0/0", stat_br_cnt, stat_miss_cnt); end
`endif
   endtask

   initial begin
      e_flush = 0; e_redirect = 0; e_err = 0; e_br_cnt = 0; e_miss_cnt = 0;
      @(posedge clk); #1;
      test_reset();
      test_correct_pred();
      test_mispredict();
      test_miss_discard();
      test_full();
      test_stall();
      test_underflow_and_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
